// File: rtl/cc_snoop_controller_pkg.sv
// Shared coherence definitions: MESI states, snoop kinds,
// cache geometry and the controller FSM encoding.
package cc_snoop_controller_pkg;

   localparam int BLOCK_WORDS  = 2;
   localparam int N_SETS       = 1024 / 8 / 4 / BLOCK_WORDS;
   localparam int N_SET_BITS   = $clog2(N_SETS);
   localparam int N_BLOCK_BITS = $clog2(BLOCK_WORDS);
   localparam int TAG_SHIFT    = N_SET_BITS + N_BLOCK_BITS + 2;

   typedef enum logic [1:0] {
      INVALID   = 2'd0,
      SHARED    = 2'd1,
      EXCLUSIVE = 2'd2,
      MODIFIED  = 2'd3
   } cc_end_state;

   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RDX  = 2'd1,
      BUS_UPGR = 2'd2
   } snoop_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2,
      FILL   = 2'd3
   } cc_fsm_t;

   // Collapse the cache's valid/exclusive/dirty bits into a MESI state.
   function automatic cc_end_state frame_state(
      input logic v,
      input logic e,
      input logic d
   );
      cc_end_state s;
      s = INVALID;
      unique case (1'b1)
         !v:            s = INVALID;
         (v && d):      s = MODIFIED;
         (v && e && !d): s = EXCLUSIVE;
         (v && !e && !d): s = SHARED;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cc_snoop_controller_if.sv
// Link between the coherency unit and one L1 cache's
// MESI state array.
interface cache_coherence_if;
   import cc_snoop_controller_pkg::*;

   logic [N_SET_BITS-1:0] set_sel;
   cc_end_state           state_transfer;
   logic [31:0]           requested_data;
   logic                  snoop_hit;
   logic                  valid;
   logic                  exclusive;
   logic                  dirty;
   logic [31:0]           frame_tag;
   logic                  write_req;

   modport coherency_unit (
      output set_sel,
      output state_transfer,
      output requested_data,
      output snoop_hit,
      input  valid,
      input  exclusive,
      input  dirty,
      input  frame_tag,
      input  write_req
   );

   modport cache (
      input  set_sel,
      input  state_transfer,
      input  requested_data,
      input  snoop_hit,
      output valid,
      output exclusive,
      output dirty,
      output frame_tag,
      output write_req
   );

endinterface

// File: rtl/cc_snoop_controller_mesi_transition.sv
// MESI next state for a snooped hit, plus the flush and
// shared indications returned to the requester.
module mesi_transition
   import cc_snoop_controller_pkg::*;
(
   input  cc_end_state cur,
   input  snoop_t      stype,
   output cc_end_state nxt,
   output logic        resp_dirty,
   output logic        resp_shared
);

   // Reads demote to SHARED; RdX and Upgr both invalidate,
   // and an Upgr that finds E or M behaves exactly like RdX.
   always_comb begin
      nxt         = INVALID;
      resp_dirty  = 1'b0;
      resp_shared = 1'b0;
      if (cur != INVALID) begin
         case (stype)
            BUS_RD: begin
               nxt         = SHARED;
               resp_dirty  = (cur == MODIFIED);
               resp_shared = 1'b1;
            end
            BUS_RDX: begin
               resp_dirty = (cur == MODIFIED);
            end
            BUS_UPGR: begin
               resp_dirty = (cur == MODIFIED);
            end
            default: begin
               resp_dirty = (cur == MODIFIED);
            end
         endcase
      end
   end

endmodule

// File: rtl/cc_snoop_controller.sv
// Coherency-unit side of one cache: serves bus snoops and
// local fills, committing MESI updates into the state array.
module cc_snoop_controller #(
   parameter int BLOCK_SIZE   = 2,
   parameter int N_SET_BITS   = $clog2(1024 / 8 / 4 / BLOCK_SIZE),
   parameter int N_BLOCK_BITS = $clog2(BLOCK_SIZE)
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            snoop_valid,
   output logic                            snoop_ready,
   input  logic [31:0]                     snoop_addr,
   input  cc_snoop_controller_pkg::snoop_t snoop_type,
   output logic                            snoop_done,
   output logic                            snoop_resp_hit,
   output logic                            snoop_resp_dirty,
   output logic                            snoop_resp_shared,
   input  logic                            fill_valid,
   output logic                            fill_ready,
   input  logic [31:0]                     fill_addr,
   input  logic                            fill_shared,
   cache_coherence_if.coherency_unit       cc
);
   import cc_snoop_controller_pkg::*;

   localparam int SET_LSB = N_BLOCK_BITS + 2;
   localparam int TAG_LSB = N_SET_BITS + N_BLOCK_BITS + 2;

   cc_fsm_t     state;
   cc_fsm_t     state_nxt;
   logic [31:0] cap_addr;
   snoop_t      cap_type;
   logic        cap_shared;
   logic        cap_wr;

   cc_end_state cur_state;
   cc_end_state mesi_nxt;
   logic        mesi_dirty;
   logic        mesi_shared;
   logic        tag_hit;
   logic        commit;
   cc_end_state xfer;

   assign cur_state = frame_state(cc.valid, cc.exclusive, cc.dirty);
   assign tag_hit   = cc.valid && ((cap_addr >> TAG_LSB) == cc.frame_tag);

   mesi_transition u_mesi (
      .cur         (cur_state),
      .stype       (cap_type),
      .nxt         (mesi_nxt),
      .resp_dirty  (mesi_dirty),
      .resp_shared (mesi_shared)
   );

   // FSM state register; reset drops any in-flight request.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // Latch the accepted request; snoop takes priority over fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cap_addr   <= '0;
         cap_type   <= BUS_RD;
         cap_shared <= 1'b0;
         cap_wr     <= 1'b0;
      end else if (state == IDLE) begin
         if (snoop_valid) begin
            cap_addr <= snoop_addr;
            cap_type <= snoop_type;
         end else if (fill_valid) begin
            cap_addr   <= fill_addr;
            cap_shared <= fill_shared;
            cap_wr     <= cc.write_req;
         end
      end
   end

   // Next-state sequencing and per-state response/commit outputs.
   always_comb begin
      state_nxt         = state;
      snoop_done        = 1'b0;
      snoop_resp_hit    = 1'b0;
      snoop_resp_dirty  = 1'b0;
      snoop_resp_shared = 1'b0;
      commit            = 1'b0;
      xfer              = INVALID;
      unique case (state)
         IDLE: begin
            if (snoop_valid)     state_nxt = LOOKUP;
            else if (fill_valid) state_nxt = FILL;
         end
         LOOKUP: state_nxt = RESP;
         RESP: begin
            snoop_done = 1'b1;
            state_nxt  = IDLE;
            if (tag_hit) begin
               snoop_resp_hit    = 1'b1;
               snoop_resp_dirty  = mesi_dirty;
               snoop_resp_shared = mesi_shared;
               commit            = 1'b1;
               xfer              = mesi_nxt;
            end
         end
         FILL: begin
            commit    = 1'b1;
            state_nxt = IDLE;
            if (cap_wr)          xfer = MODIFIED;
            else if (cap_shared) xfer = SHARED;
            else                 xfer = EXCLUSIVE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign snoop_ready       = (state == IDLE);
   assign fill_ready        = (state == IDLE);
   assign cc.set_sel        = cap_addr[SET_LSB +: N_SET_BITS];
   assign cc.requested_data = {cap_addr[31:2], 2'b00};
   assign cc.snoop_hit      = commit;
   assign cc.state_transfer = xfer;

endmodule

// File: tb/tb_cc_snoop_controller.sv
// Self-checking bench for cc_snoop_controller: directed
// scenarios plus randomized snoops/fills against a MESI model.
module tb_cc_snoop_controller;
   import cc_snoop_controller_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic        snoop_valid;
   logic        snoop_ready;
   logic [31:0] snoop_addr;
   snoop_t      snoop_type;
   logic        snoop_done;
   logic        resp_hit;
   logic        resp_dirty;
   logic        resp_shared;
   logic        fill_valid;
   logic        fill_ready;
   logic [31:0] fill_addr;
   logic        fill_shared;

   int checks = 0;
   int failures = 0;

   cache_coherence_if ccif ();

   cc_snoop_controller dut (
      .CLK               (clk),
      .nRST              (nrst),
      .snoop_valid       (snoop_valid),
      .snoop_ready       (snoop_ready),
      .snoop_addr        (snoop_addr),
      .snoop_type        (snoop_type),
      .snoop_done        (snoop_done),
      .snoop_resp_hit    (resp_hit),
      .snoop_resp_dirty  (resp_dirty),
      .snoop_resp_shared (resp_shared),
      .fill_valid        (fill_valid),
      .fill_ready        (fill_ready),
      .fill_addr         (fill_addr),
      .fill_shared       (fill_shared),
      .cc                (ccif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hit;
      logic        commit;
      cc_end_state nxt;
      logic        dirty;
      logic        shared;
   } exp_t;

   typedef struct packed {
      logic [3:0]  l_set;
      logic [31:0] l_req;
      logic        l_done;
      logic        l_shit;
      logic        r_done;
      logic        r_rhit;
      logic        r_dirty;
      logic        r_shared;
      logic        r_shit;
      cc_end_state r_xfer;
      logic [3:0]  r_set;
      logic        i_done;
      logic        i_ready;
   } obs_t;

   // MESI rules written from the protocol description:
   // tag sits above bit 6, reads share, RdX/Upgr invalidate.
   function automatic exp_t ref_snoop(
      input logic [31:0] addr,
      input snoop_t      t,
      input logic        v,
      input logic        e,
      input logic        d,
      input logic [31:0] ftag
   );
      exp_t        r;
      cc_end_state s;
      if (!v)     s = INVALID;
      else if (d) s = MODIFIED;
      else if (e) s = EXCLUSIVE;
      else        s = SHARED;
      r = '0;
      r.nxt = INVALID;
      r.hit = v && (ftag == (addr / 128));
      if (r.hit) begin
         r.commit = 1'b1;
         r.dirty  = (s == MODIFIED);
         if (t == BUS_RD) begin
            r.nxt    = SHARED;
            r.shared = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] set_of(input logic [31:0] a);
      return 4'((a / 8) % 16);
   endfunction

   task automatic run_snoop(
      input  logic [31:0] a,
      input  snoop_t      t,
      input  logic        v,
      input  logic        e,
      input  logic        d,
      input  logic [31:0] ftag,
      output obs_t        o
   );
      @(negedge clk);
      snoop_addr     = a;
      snoop_type     = t;
      snoop_valid    = 1'b1;
      ccif.valid     = v;
      ccif.exclusive = e;
      ccif.dirty     = d;
      ccif.frame_tag = ftag;
      @(negedge clk);
      snoop_valid = 1'b0;
      o.l_set  = ccif.set_sel;
      o.l_req  = ccif.requested_data;
      o.l_done = snoop_done;
      o.l_shit = ccif.snoop_hit;
      @(negedge clk);
      o.r_done   = snoop_done;
      o.r_rhit   = resp_hit;
      o.r_dirty  = resp_dirty;
      o.r_shared = resp_shared;
      o.r_shit   = ccif.snoop_hit;
      o.r_xfer   = ccif.state_transfer;
      o.r_set    = ccif.set_sel;
      @(negedge clk);
      o.i_done  = snoop_done;
      o.i_ready = snoop_ready;
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      snoop_valid = 1'b0;
      snoop_addr = '0;
      snoop_type = BUS_RD;
      fill_valid = 1'b0;
      fill_addr = '0;
      fill_shared = 1'b0;
      ccif.valid = 1'b0;
      ccif.exclusive = 1'b0;
      ccif.dirty = 1'b0;
      ccif.frame_tag = '0;
      ccif.write_req = 1'b0;
      #22;
      checks++;
      if (snoop_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_done got=%b want=0", snoop_done);
      end
      checks++;
      if ({resp_hit, resp_dirty, resp_shared} !== 3'b000) begin
         failures++;
         $display("FAIL rst_resp got=%b%b%b want=000",
                  resp_hit, resp_dirty, resp_shared);
      end
      checks++;
      if (ccif.snoop_hit !== 1'b0) begin
         failures++;
         $display("FAIL rst_shit got=%b want=0", ccif.snoop_hit);
      end
      checks++;
      if (ccif.set_sel !== 4'd0) begin
         failures++;
         $display("FAIL rst_set got=%0d want=0", ccif.set_sel);
      end
      checks++;
      if (ccif.requested_data !== 32'd0) begin
         failures++;
         $display("FAIL rst_req got=%h want=0", ccif.requested_data);
      end
      checks++;
      if (ccif.state_transfer !== INVALID) begin
         failures++;
         $display("FAIL rst_xfer got=%0d want=0", ccif.state_transfer);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      checks++;
      if ({snoop_ready, fill_ready} !== 2'b11) begin
         failures++;
         $display("FAIL rst_ready got=%b%b want=11",
                  snoop_ready, fill_ready);
      end
   endtask

   task automatic test_bus_rd_modified;
      obs_t o;
      run_snoop(32'h0000_1238, BUS_RD, 1'b1, 1'b0, 1'b1, 32'h24, o);
      checks++;
      if (o.l_set !== 4'd7 || o.l_done !== 1'b0 || o.l_shit !== 1'b0) begin
         failures++;
         $display("FAIL rd_lookup got=set%0d done%b hit%b want=set7 done0 hit0",
                  o.l_set, o.l_done, o.l_shit);
      end
      checks++;
      if (o.l_req !== 32'h0000_1238) begin
         failures++;
         $display("FAIL rd_req got=%h want=00001238", o.l_req);
      end
      checks++;
      if (o.r_done !== 1'b1 || o.r_shit !== 1'b1 || o.r_set !== 4'd7) begin
         failures++;
         $display("FAIL rd_commit got=done%b hit%b set%0d want=done1 hit1 set7",
                  o.r_done, o.r_shit, o.r_set);
      end
      checks++;
      if (o.r_xfer !== SHARED) begin
         failures++;
         $display("FAIL rd_xfer got=%0d want=%0d", o.r_xfer, SHARED);
      end
      checks++;
      if ({o.r_rhit, o.r_dirty, o.r_shared} !== 3'b111) begin
         failures++;
         $display("FAIL rd_resp got=%b%b%b want=111",
                  o.r_rhit, o.r_dirty, o.r_shared);
      end
      checks++;
      if (o.i_done !== 1'b0 || o.i_ready !== 1'b1) begin
         failures++;
         $display("FAIL rd_idle got=done%b rdy%b want=done0 rdy1",
                  o.i_done, o.i_ready);
      end
   endtask

   task automatic test_bus_rdx_exclusive;
      obs_t o;
      run_snoop(32'h0000_1238, BUS_RDX, 1'b1, 1'b1, 1'b0, 32'h24, o);
      checks++;
      if (o.r_shit !== 1'b1 || o.r_xfer !== INVALID) begin
         failures++;
         $display("FAIL rdx_commit got=hit%b st%0d want=hit1 st0",
                  o.r_shit, o.r_xfer);
      end
      checks++;
      if ({o.r_rhit, o.r_dirty, o.r_shared} !== 3'b100) begin
         failures++;
         $display("FAIL rdx_resp got=%b%b%b want=100",
                  o.r_rhit, o.r_dirty, o.r_shared);
      end
   endtask

   task automatic test_tag_miss;
      obs_t o;
      run_snoop(32'h0000_1238, BUS_RD, 1'b1, 1'b0, 1'b1, 32'h25, o);
      checks++;
      if (o.r_done !== 1'b1 || o.r_shit !== 1'b0) begin
         failures++;
         $display("FAIL miss_done got=done%b hit%b want=done1 hit0",
                  o.r_done, o.r_shit);
      end
      checks++;
      if ({o.r_rhit, o.r_dirty, o.r_shared} !== 3'b000) begin
         failures++;
         $display("FAIL miss_resp got=%b%b%b want=000",
                  o.r_rhit, o.r_dirty, o.r_shared);
      end
   endtask

   task automatic test_random_snoops;
      for (int i = 0; i < 60; i++) begin
         obs_t        o;
         exp_t        x;
         logic [31:0] a;
         logic [31:0] ft;
         snoop_t      t;
         logic        v, e, d;
         a  = $urandom;
         t  = snoop_t'($urandom_range(0, 2));
         v  = ($urandom_range(0, 4) != 0);
         e  = 1'($urandom);
         d  = 1'($urandom);
         ft = a / 128;
         if ($urandom_range(0, 3) == 0) ft = ft ^ 32'($urandom_range(1, 255));
         x = ref_snoop(a, t, v, e, d, ft);
         run_snoop(a, t, v, e, d, ft, o);
         checks++;
         if (o.r_done !== 1'b1 || o.r_rhit !== x.hit || o.r_shit !== x.commit) begin
            failures++;
            $display("FAIL rnd_hit[%0d] got=done%b rh%b sh%b want=done1 rh%b sh%b",
                     i, o.r_done, o.r_rhit, o.r_shit, x.hit, x.commit);
         end
         checks++;
         if (o.r_dirty !== x.dirty || o.r_shared !== x.shared) begin
            failures++;
            $display("FAIL rnd_resp[%0d] got=d%b s%b want=d%b s%b",
                     i, o.r_dirty, o.r_shared, x.dirty, x.shared);
         end
         if (x.commit) begin
            checks++;
            if (o.r_xfer !== x.nxt) begin
               failures++;
               $display("FAIL rnd_xfer[%0d] got=%0d want=%0d",
                        i, o.r_xfer, x.nxt);
            end
         end
         checks++;
         if (o.r_set !== set_of(a) || o.l_req !== (a & ~32'h3)) begin
            failures++;
            $display("FAIL rnd_addr[%0d] got=set%0d req%h want=set%0d req%h",
                     i, o.r_set, o.l_req, set_of(a), a & ~32'h3);
         end
      end
   endtask

   task automatic test_random_fills;
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         logic        sh, wr;
         cc_end_state want;
         a  = $urandom;
         sh = 1'($urandom);
         wr = 1'($urandom);
         want = wr ? MODIFIED : (sh ? SHARED : EXCLUSIVE);
         @(negedge clk);
         fill_addr      = a;
         fill_shared    = sh;
         ccif.write_req = wr;
         fill_valid     = 1'b1;
         @(negedge clk);
         fill_valid = 1'b0;
         checks++;
         if (ccif.snoop_hit !== 1'b1 || ccif.state_transfer !== want ||
             ccif.set_sel !== set_of(a) || snoop_done !== 1'b0) begin
            failures++;
            $display("FAIL fill[%0d] got=hit%b st%0d set%0d done%b want=hit1 st%0d set%0d done0",
                     i, ccif.snoop_hit, ccif.state_transfer, ccif.set_sel,
                     snoop_done, want, set_of(a));
         end
         @(negedge clk);
         checks++;
         if (ccif.snoop_hit !== 1'b0 || fill_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_idle[%0d] got=hit%b rdy%b want=hit0 rdy1",
                     i, ccif.snoop_hit, fill_ready);
         end
      end
   endtask

   task automatic test_back_to_back;
      int done_cyc;
      int fill_cyc;
      done_cyc = -1;
      fill_cyc = -1;
      @(negedge clk);
      snoop_addr     = 32'h0000_1238;
      snoop_type     = BUS_RD;
      snoop_valid    = 1'b1;
      fill_addr      = 32'h0000_0A3C;
      fill_shared    = 1'b0;
      fill_valid     = 1'b1;
      ccif.write_req = 1'b1;
      ccif.valid     = 1'b1;
      ccif.exclusive = 1'b1;
      ccif.dirty     = 1'b0;
      ccif.frame_tag = 32'h24;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         snoop_valid = 1'b0;
         if (snoop_done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (snoop_done !== 1'b1 && ccif.snoop_hit === 1'b1 && fill_cyc < 0) begin
            fill_cyc = c;
            fill_valid = 1'b0;
            checks++;
            if (ccif.state_transfer !== MODIFIED || ccif.set_sel !== 4'd7) begin
               failures++;
               $display("FAIL b2b_fill got=st%0d set%0d want=st3 set7",
                        ccif.state_transfer, ccif.set_sel);
            end
         end
      end
      fill_valid = 1'b0;
      checks++;
      if (done_cyc != 2) begin
         failures++;
         $display("FAIL b2b_snoop_cycle got=%0d want=2", done_cyc);
      end
      checks++;
      if (fill_cyc != 4) begin
         failures++;
         $display("FAIL b2b_fill_cycle got=%0d want=4", fill_cyc);
      end
   endtask

   task automatic test_reset_mid;
      int pulses;
      pulses = 0;
      @(negedge clk);
      snoop_addr     = 32'h0000_1238;
      snoop_type     = BUS_RDX;
      snoop_valid    = 1'b1;
      ccif.valid     = 1'b1;
      ccif.exclusive = 1'b0;
      ccif.dirty     = 1'b1;
      ccif.frame_tag = 32'h24;
      @(negedge clk);
      snoop_valid = 1'b0;
      checks++;
      if (ccif.set_sel !== 4'd7 || snoop_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_lookup got=set%0d rdy%b want=set7 rdy0",
                  ccif.set_sel, snoop_ready);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if (snoop_ready !== 1'b1 || ccif.set_sel !== 4'd0) begin
         failures++;
         $display("FAIL mid_rst got=rdy%b set%0d want=rdy1 set0",
                  snoop_ready, ccif.set_sel);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 1) nrst = 1'b1;
         if (snoop_done === 1'b1 || ccif.snoop_hit === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL mid_pulses got=%0d want=0", pulses);
      end
      checks++;
      if (snoop_ready !== 1'b1 || fill_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_idle got=%b%b want=11", snoop_ready, fill_ready);
      end
   endtask

   initial begin
      test_reset();
      test_bus_rd_modified();
      test_bus_rdx_exclusive();
      test_tag_miss();
      test_random_snoops();
      test_random_fills();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
